// File: rtl/lsu_sram_ctrl.sv
// LSU to async SRAM bridge: one 32-bit access as two 16-bit phases.
// Optional LSU_SRAM_RDSKIP_EN: loads honour the byte mask.
module lsu_sram_ctrl #(
  parameter int          ADDR_W   = 18,
  parameter int          WAIT_CYC = 1,
  parameter logic [31:0] RD_INIT  = 32'h0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_wren,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_bmask,
  output logic              o_ready,
  output logic              o_ack,
  output logic [31:0]       o_rdata,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_UB_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYC);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        bmask_q, bmask_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       rdata_q, rdata_d;

  logic       unused_addr;
  logic [3:0] mask_in;
  logic       last, ld, act, hi, strobe, drive;
  logic [15:0] dout;

  assign unused_addr = ^{i_addr[31:ADDR_W+1], i_addr[1:0]};
  assign last        = (cnt_q == WC);

  // The latched mask drives both phase skipping and lane enables.
  always_comb begin
`ifdef LSU_SRAM_RDSKIP_EN
    mask_in = i_bmask;
`else
    mask_in = i_wren ? i_bmask : 4'hF;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wren_d  = wren_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    ld      = !wren_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        ld    = !i_wren;
        if (i_req) begin
          wren_d  = i_wren;
          addr_d  = i_addr[ADDR_W:2];
          wdata_d = i_wdata;
          bmask_d = mask_in;
          rbuf_d  = '0;
          if (|mask_in[1:0])      state_d = LO;
          else if (|mask_in[3:2]) state_d = HI;
          else                    state_d = DONE;
        end
      end
      LO: begin
        if (last) begin
          cnt_d = '0;
          if (!wren_q) rbuf_d[15:0] = SRAM_DQ;
          state_d = (|bmask_q[3:2]) ? HI : DONE;
        end else begin
          cnt_d = 4'(cnt_q + 4'd1);
        end
      end
      HI: begin
        if (last) begin
          cnt_d = '0;
          if (!wren_q) rbuf_d[31:16] = SRAM_DQ;
          state_d = DONE;
        end else begin
          cnt_d = 4'(cnt_q + 4'd1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Whole-word update so o_rdata is never seen half-written.
    if (state_q != DONE && state_d == DONE && ld)
      rdata_d = rbuf_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= RD_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Pins decode straight from state so reset drops strobes at once.
  always_comb begin
    act       = (state_q == LO) || (state_q == HI);
    hi        = (state_q == HI);
    strobe    = act && (cnt_q != 4'd0);
    drive     = act && wren_q;
    dout      = hi ? wdata_q[31:16] : wdata_q[15:0];
    SRAM_ADDR = act ? {addr_q, hi} : '0;
    SRAM_CE_N = !act;
    SRAM_WE_N = !(strobe && wren_q);
    SRAM_OE_N = !(strobe && !wren_q);
    SRAM_LB_N = act ? !(hi ? bmask_q[2] : bmask_q[0]) : 1'b1;
    SRAM_UB_N = act ? !(hi ? bmask_q[3] : bmask_q[1]) : 1'b1;
  end

  assign SRAM_DQ = drive ? dout : 16'hzzzz;
  assign o_ready = (state_q == IDLE);
  assign o_ack   = (state_q == DONE);
  assign o_rdata = rdata_q;

endmodule
